// File: rtl/cpu_pkg.sv
// Shared constants for the memory responder: FSM state encoding, default
// latency and memory geometry, plus the captured-request record.
package cpu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_LATENCY = 2;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_DEPTH   = 2 ** DEF_ADDR_W;

  // Wide enough for the full 0-15 latency range.
  localparam int CNT_W = 4;

  typedef struct packed {
    logic        is_write;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous 32-bit RAM. The storage is never reset; only the
// registered read port clears, so Mdatain reads 0 right after reset.
module ram_array
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)    rdata_q <= '0;
    else if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Latency-programmable memory responder: accepts one read or write in IDLE,
// waits LATENCY cycles, then completes the access with a one-cycle ready.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for exactly one of Read/Write; both high pulses err
//   WAIT    | request captured, counting cnt down to zero
//   DONE    | access performed on entry, ready high for this one cycle
module mem_responder
  import cpu_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       Mdatain,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  req_t              req_q, req_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    req_d   = req_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Read ^ Write) begin
          state_d        = ST_WAIT;
          cnt_d          = LAT_CNT;
          addr_d         = addr;
          req_d.is_write = Write;
          req_d.wdata    = wdata;
          busy_d         = 1'b1;
        end else if (Read && Write) begin
          err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // Terminal count: the RAM access lands on the same edge as DONE entry.
        if (cnt_q == '0) begin
          fire    = 1'b1;
          state_d = ST_DONE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (2 ** ADDR_W)
  ) u_ram (
    .clk   (clk),
    .clr   (clr),
    .we    (fire & req_q.is_write),
    .re    (fire & ~req_q.is_write),
    .addr  (addr_q),
    .wdata (req_q.wdata),
    .rdata (Mdatain)
  );

  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, meaning wait cycles between request acceptance and completion (range 0-15).
REQ-002 Parameter ADDR_W, default 9, meaning word-address width (DEPTH = 2**ADDR_W = 512 words).
REQ-003 clk  input  1  rising-edge system clock shared with the datapath.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 Read  input  1  read request from the datapath control.
REQ-006 Write  input  1  write request from the datapath control.
REQ-007 addr  input  ADDR_W  word address, the low bits of MAR.
REQ-008 wdata  input  32  write data, driven from MDR.
REQ-009 Mdatain  output  32  read data returned to the datapath MDR input.
REQ-010 ready  output  1  one-cycle completion pulse for a read or a write.
REQ-011 busy  output  1  request in progress; new requests are ignored.
REQ-012 err  output  1  one-cycle pulse when Read and Write are both high in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and DONE; all outputs are registered.
REQ-014 In IDLE with exactly one of Read/Write high at edge k, the block SHALL capture addr, wdata and op, set busy=1 and enter WAIT with cnt=LATENCY.
REQ-015 In WAIT, each edge SHALL decrement cnt; the edge that sees cnt==0 enters DONE, so DONE is entered at edge k+LATENCY+1.
REQ-016 On entry to DONE for a read, Mdatain SHALL load mem[addr_q]; for a write, mem[addr_q] SHALL load wdata_q; ready=1 in both cases.
REQ-017 DONE SHALL last exactly one cycle; at edge k+LATENCY+2 the FSM returns to IDLE with ready=0 and busy=0.
REQ-018 Requests SHALL be accepted only in IDLE; the earliest next acceptance is edge k+LATENCY+3.
REQ-019 Read/Write/addr/wdata changes while busy SHALL be ignored and SHALL not alter the captured operation.
REQ-020 Read=Write=1 in IDLE SHALL pulse err for one cycle, perform no access and keep the FSM in IDLE.
REQ-021 Mdatain SHALL hold the last read value until the next read completes; writes SHALL not change it.
REQ-022 With LATENCY=0, the FSM SHALL go IDLE->WAIT->DONE, with ready at edge k+1.
REQ-023 A read of an address written by an earlier completed write SHALL return the written data.

Reset
REQ-024 clr low SHALL immediately force state=IDLE, cnt=0, Mdatain=0, ready=0, busy=0 and err=0.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 A reset asserted during WAIT SHALL abort the operation: no write is committed and no ready is issued.
REQ-027 After clr deasserts, the first request SHALL be accepted no earlier than the first rising edge with clr high.

Structure
REQ-028 The shared package cpu_pkg SHALL hold the state encoding constants, the default LATENCY and the ADDR_W/DEPTH constants.
REQ-029 The storage array SHALL be a sub-module ram_array (single-port synchronous 32-bit RAM, DEPTH words, write-enable and read registered into Mdatain).
REQ-030 The FSM and latency counter SHALL live in mem_responder.

Verification
REQ-031 Write/read with LATENCY=2:
- Stimulus: Write addr=0x005 wdata=0x0000_00AB, then Read addr=0x005.
- Response: each ready exactly 3 edges after acceptance, and Mdatain=0x0000_00AB.
REQ-032 Back-to-back request while busy:
- Stimulus: Read addr=0x010 accepted, then Write addr=0x010 wdata=0xFFFF_FFFF held high during WAIT.
- Response: the write is ignored, with exactly one ready.
REQ-033 Simultaneous requests:
- Stimulus: Read=Write=1 in IDLE.
- Response: err=1 for one cycle, busy stays 0, and memory and Mdatain are unchanged.
REQ-034 Reset mid-operation:
- Stimulus: Write addr=0x020 wdata=0x1234_5678; clr low during WAIT; then Read addr=0x020.
- Response: the read returns the prior contents, and Mdatain=0 immediately after reset.
REQ-035 LATENCY=0:
- Stimulus: Read addr=0x1FF.
- Response: ready at edge k+1 and busy low at edge k+2.
REQ-036 Wrap/boundary:
- Stimulus: Write 0x1FF=0xDEAD_BEEF and 0x000=0x0000_0001, then read both.
- Response: no aliasing, and each returns its own value.
